// File: rtl/key_debounce_if.sv
// Key debouncer port bundle: raw active-low key pins in, debounced level and
// single-cycle press/release/long strobes out.
interface key_debounce_if #(
  parameter int unsigned N_KEYS = 32'd4
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;

  modport master (
    output key_n,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_n,
    output key_state,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key 2-FF synchronizer + debounce FSM with registered press/release strobes.
// Long-press detection is compiled in only when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
  parameter int unsigned CLK_FREQ_HZ = 32'd200_000_000,
  parameter int unsigned DEBOUNCE_MS = 32'd20,
  parameter int unsigned LONG_MS     = 32'd1000,
  parameter int unsigned N_KEYS      = 32'd4
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  key_debounce_if.slave  kif
);

  localparam logic [31:0] DEB_CYCLES  = 32'(CLK_FREQ_HZ / 32'd1000 * DEBOUNCE_MS);
  localparam logic [31:0] LONG_CYCLES = 32'(CLK_FREQ_HZ / 32'd1000 * LONG_MS);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_HELD       = 2'd2,
    ST_REL_WAIT   = 2'd3
  } state_e;

  // Saturating increment keeps counters pinned at their limit instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    if (v >= lim) begin
      return lim;
    end else begin
      return v + 32'd1;
    end
  endfunction

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] kl;
  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [31:0]       cnt_q   [N_KEYS];
  logic [31:0]       cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] key_state_q, key_state_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
`ifdef KEY_LONG_PRESS_EN
  logic [N_KEYS-1:0] long_q, long_d;
`endif

  assign kl = ~sync2_q;

  // Synchronizer resets to "released" so leaving reset never looks like a press.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= kif.key_n;
      sync2_q <= sync1_q;
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_KEYS); i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= 32'd0;
      end
      key_state_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
`ifdef KEY_LONG_PRESS_EN
      long_q      <= '0;
`endif
    end else begin
      for (int i = 0; i < int'(N_KEYS); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
`ifdef KEY_LONG_PRESS_EN
      long_q      <= long_d;
`endif
    end
  end

  // Next-state and strobe decode, one independent FSM per key.
  always_comb begin
    key_state_d = '0;
    press_d     = '0;
    release_d   = '0;
`ifdef KEY_LONG_PRESS_EN
    long_d      = '0;
`endif
    for (int i = 0; i < int'(N_KEYS); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          cnt_d[i] = 32'd0;
          if (kl[i]) begin
            state_d[i] = ST_PRESS_WAIT;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!kl[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = 32'd0;
          end else if (cnt_q[i] == DEB_CYCLES - 32'd1) begin
            state_d[i] = ST_HELD;
            press_d[i] = 1'b1;
            cnt_d[i]   = 32'd0;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i], DEB_CYCLES);
          end
        end
        ST_HELD: begin
          if (!kl[i]) begin
            state_d[i] = ST_REL_WAIT;
            cnt_d[i]   = 32'd0;
          end else begin
`ifdef KEY_LONG_PRESS_EN
            cnt_d[i]  = sat_inc(cnt_q[i], LONG_CYCLES);
            long_d[i] = (cnt_q[i] == LONG_CYCLES - 32'd1);
`else
            cnt_d[i]  = 32'd0;
`endif
          end
        end
        ST_REL_WAIT: begin
          // A bounce back to pressed restarts long-press timing from zero.
          if (kl[i]) begin
            state_d[i] = ST_HELD;
            cnt_d[i]   = 32'd0;
          end else if (cnt_q[i] == DEB_CYCLES - 32'd1) begin
            state_d[i]   = ST_IDLE;
            release_d[i] = 1'b1;
            cnt_d[i]     = 32'd0;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i], DEB_CYCLES);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = 32'd0;
        end
      endcase
      key_state_d[i] = (state_d[i] == ST_HELD) || (state_d[i] == ST_REL_WAIT);
    end
  end

  assign kif.key_state   = key_state_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
`ifdef KEY_LONG_PRESS_EN
  assign kif.key_long    = long_q;
`else
  assign kif.key_long    = '0;
`endif

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-side counterpart to the board LED blinker: conditions the four active-low user pushbuttons into clean, synchronous key events on `sys_clk` (200 MHz). Each key has a 2-FF synchronizer, a debounce state machine and single-cycle press/release strobes, plus optional long-press detection. It sits between the board key pins and any user logic (LED control, mode select) that needs one clean event per physical press.

## Interface
- `CLK_FREQ_HZ`, 200_000_000, `sys_clk` frequency in Hz.
- `DEBOUNCE_MS`, 20, stable-level time required to accept a press or a release.
- `LONG_MS`, 1000, hold time, measured from the accepted press, that qualifies as a long press.
- `N_KEYS`, 4, number of keys (1..8).
- `sys_clk`  input  1  system clock, 200 MHz.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `key_n`  input  N_KEYS  raw key pins, active-low, asynchronous to `sys_clk`.
- `key_state`  output  N_KEYS  debounced level; 1 = held.
- `key_press`  output  N_KEYS  1-cycle strobe on an accepted press.
- `key_release`  output  N_KEYS  1-cycle strobe on an accepted release.
- `key_long`  output  N_KEYS  1-cycle strobe on long-press qualification (see Configuration).

## Operation
- Derived constants, computed at elaboration:
  - `DEB_CYCLES = CLK_FREQ_HZ/1000*DEBOUNCE_MS`, which is 4_000_000 at the defaults.
  - `LONG_CYCLES = CLK_FREQ_HZ/1000*LONG_MS`, which is 200_000_000 at the defaults.
  - Each per-key counter is 32-bit unsigned and saturates, never wrapping.
- Synchronizer: two flops per key with reset value 1 (released), so deassertion of reset never produces a spurious press. `kl` = synchronized, inverted level (1 = pressed).
- Per-key FSM, fully independent per key:
  - IDLE: `key_state`=0, counter=0. If `kl`=1, go to PRESS_WAIT with counter=0.
  - PRESS_WAIT: while `kl`=1, counter increments.
    - If `kl`=0 (bounce), return to IDLE with no strobe.
    - If `kl`=1 and counter==DEB_CYCLES-1, go to HELD: set `key_state`=1, pulse `key_press`, clear counter.
  - HELD: `key_state`=1; counter increments and saturates at LONG_CYCLES.
    - If `kl`=0, go to REL_WAIT and clear counter.
    - `key_long` pulses once when counter==LONG_CYCLES-1, only if still in HELD.
  - REL_WAIT: `key_state` stays 1; while `kl`=0, counter increments.
    - If `kl`=1 (bounce), return to HELD. The counter restarts from 0, so long-press timing restarts.
    - If `kl`=0 and counter==DEB_CYCLES-1, go to IDLE: set `key_state`=0, pulse `key_release`.
- Simultaneous events on different keys are independent; strobes may coincide in the same cycle.
- At most one `key_press` and one `key_release` per accepted press cycle. At most one `key_long` per HELD entry.

## Timing
- Reset, asynchronous: all outputs = 0, all FSMs = IDLE, counters = 0, synchronizers = 1. Asserting reset mid-press aborts the press without a release strobe. After deassertion, a key still held must re-qualify through PRESS_WAIT.
- Press latency: `key_n` falls and stays low, sampled at edge E0. `kl`=1 is visible at E2 and PRESS_WAIT is entered at E2. `key_state` and `key_press` are registered high at edge E2+DEB_CYCLES. `key_press` is high for exactly one cycle.
- Release latency: same structure; `key_release` at edge E2+DEB_CYCLES after `key_n` rises.
- `key_long` occurs LONG_CYCLES cycles after the `key_press` edge, provided there are no release bounces.
- All outputs are registered, with no combinational path from `key_n`.

## Configuration
- `KEY_LONG_PRESS_EN` defined: long-press logic is compiled in as described.
- Not defined: `key_long` is tied to 0, and the HELD counter is not compiled in (the counter is used only in the WAIT states). All other behaviour is identical.

## Test plan
Bench parameters: `CLK_FREQ_HZ`=10_000, `DEBOUNCE_MS`=2 (DEB_CYCLES=20), `LONG_MS`=10 (LONG_CYCLES=100), `N_KEYS`=4, `KEY_LONG_PRESS_EN` defined.
- Reset, then hold `key_n`=4'hF for 200 cycles: all outputs stay 0. Release reset while `key_n[0]`=0: no `key_press` until 22 cycles after deassertion.
- Clean press: `key_n[1]` low at E0 and held. `key_press[1]` is a 1-cycle pulse at E22, `key_state[1]`=1 from E22. Raise `key_n[1]` at E50: `key_release[1]` at E72, `key_state[1]`=0.
- Bounce: `key_n[2]` toggles low/high every 5 cycles for 100 cycles, then stays high: no strobes, `key_state[2]`=0 throughout.
- Long press: hold `key_n[3]` low. `key_press[3]` at E22, `key_long[3]` once at E122, no repeat through E400. Release: one `key_release[3]`.
- Release bounce: key 0 held, then a 10-cycle high glitch: `key_state[0]` stays 1, no `key_release`.
- Simultaneous: all keys go low at the same edge. `key_press`=4'hF in one cycle at E22. Rebuild without the macro: `key_long`=0 always.
